aes_key_expand_seq: RTL and testbench

Sequential AES key-schedule engine that turns a cipher key into the full round-key set. It produces one 32-bit schedule word per clock and stores all words in an internal buffer. Round keys are then served by round index to a downstream round-based encrypt/decrypt datapath. It is parameterised the same way as the team's AES cores (key width, round count, key words), so one instance supports each of AES-128/192/256.

---
 rtl/aes_key_expand_seq.sv | 215 +++++++++++++++++++++
 tb/tb_aes_key_expand_seq.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expand_seq.sv
// AES key-schedule engine: expands a 128/192/256-bit cipher key at one
// 32-bit word per clock into a round-key buffer that is read by round index.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  function automatic logic [7:0] xtime8(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] m);
    logic [7:0] p;
    logic [7:0] s;
    p = 8'h00;
    s = x;
    for (int k = 0; k < 8; k++) begin
      p = p ^ (s & {8{m[k]}});
      s = xtime8(s);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8) and maps 0 onto 0
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = x;
    for (int k = 1; k < 8; k++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // S-box substitution: field inverse followed by the affine map
  always_comb begin
    y = affine(gf_inv(a));
  end

endmodule

module aes_key_expand_seq #(
  parameter int N  = 128,
  parameter int Nr = 10,
  parameter int Nk = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   key_in,
  output logic           busy,
  output logic           done,
  output logic           key_valid,
  input  logic [3:0]     rd_idx,
  output logic [127:0]   rd_key
);

  localparam int W  = 4 * (Nr + 1);
  localparam int IW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [IW-1:0] i_r;
  logic [2:0]    j_r;
  logic [7:0]    rcon_r;
  logic          busy_r;
  logic          done_r;
  logic          key_valid_r;
  logic [31:0]   w_r [W];

  logic [31:0]   prev_s;
  logic [31:0]   sub_in_s;
  logic [31:0]   sub_s;
  logic [31:0]   temp_s;
  logic [31:0]   new_word_s;
  logic          last_s;
  logic [IW-1:0] rd_base_s;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  assign prev_s   = w_r[i_r - IW'(1)];
  assign sub_in_s = (j_r == 3'd0) ? {prev_s[23:0], prev_s[31:24]} : prev_s;
  assign last_s   = (i_r == IW'(W - 1));

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .a (sub_in_s[8*b +: 8]),
      .y (sub_s[8*b +: 8])
    );
  end

  // Schedule word rule: RotWord/SubWord/Rcon at j==0, extra SubWord for 256-bit keys
  always_comb begin
    temp_s = prev_s;
    if (j_r == 3'd0) begin
      temp_s = sub_s ^ {rcon_r, 24'h000000};
    end else if ((Nk == 8) && (j_r == 3'd4)) begin
      temp_s = sub_s;
    end else begin
      temp_s = prev_s;
    end
    new_word_s = w_r[i_r - IW'(Nk)] ^ temp_s;
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = EXPAND;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      EXPAND: begin
        if (last_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = EXPAND;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, word counters, rcon and registered status flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      i_r         <= '0;
      j_r         <= 3'd0;
      rcon_r      <= 8'h00;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      key_valid_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == EXPAND);
      done_r  <= (state_nxt_s == DONE);
      case (state_r)
        IDLE: begin
          if (start) begin
            i_r         <= IW'(Nk);
            j_r         <= 3'd0;
            rcon_r      <= 8'h01;
            key_valid_r <= 1'b0;
          end
        end
        EXPAND: begin
          i_r <= i_r + IW'(1);
          j_r <= (j_r == 3'(Nk - 1)) ? 3'd0 : j_r + 3'd1;
          if (j_r == 3'd0) begin
            rcon_r <= xtime(rcon_r);
          end
          if (last_s) begin
            key_valid_r <= 1'b1;
          end
        end
        DONE: begin
          i_r <= i_r;
        end
        default: begin
          i_r <= '0;
        end
      endcase
    end
  end

  // Word buffer; contents only matter once key_valid is set, so it is not reset
  always_ff @(posedge clk) begin
    if ((state_r == IDLE) && start) begin
      for (int k = 0; k < Nk; k++) begin
        w_r[k] <= key_in[N - 1 - 32*k -: 32];
      end
    end else if (state_r == EXPAND) begin
      w_r[i_r] <= new_word_s;
    end
  end

  assign rd_base_s = IW'({rd_idx, 2'b00});

  // Combinational round-key read, masked until the schedule is complete
  always_comb begin
    rd_key = 128'h0;
    if (key_valid_r && (rd_idx <= 4'(Nr))) begin
      rd_key = {w_r[rd_base_s], w_r[rd_base_s + IW'(1)],
                w_r[rd_base_s + IW'(2)], w_r[rd_base_s + IW'(3)]};
    end else begin
      rd_key = 128'h0;
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign key_valid = key_valid_r;

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Self-checking bench for aes_key_expand_seq: AES-128/192/256 instances checked
// every cycle against a FIPS-197 style key-schedule model, plus literal vectors.

module tb_aes_key_expand_seq;

  logic         clk = 1'b0;
  logic         reset;
  logic         start_s   [3];
  logic [255:0] key_s     [3];
  logic [3:0]   rd_idx_s  [3];
  logic         busy_s    [3];
  logic         done_s    [3];
  logic         kv_s      [3];
  logic [127:0] rd_key_s  [3];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  aes_key_expand_seq #(.N(128), .Nr(10), .Nk(4)) dut128 (
    .clk(clk), .reset(reset), .start(start_s[0]), .key_in(key_s[0][255:128]),
    .busy(busy_s[0]), .done(done_s[0]), .key_valid(kv_s[0]),
    .rd_idx(rd_idx_s[0]), .rd_key(rd_key_s[0]));

  aes_key_expand_seq #(.N(192), .Nr(12), .Nk(6)) dut192 (
    .clk(clk), .reset(reset), .start(start_s[1]), .key_in(key_s[1][255:64]),
    .busy(busy_s[1]), .done(done_s[1]), .key_valid(kv_s[1]),
    .rd_idx(rd_idx_s[1]), .rd_key(rd_key_s[1]));

  aes_key_expand_seq #(.N(256), .Nr(14), .Nk(8)) dut256 (
    .clk(clk), .reset(reset), .start(start_s[2]), .key_in(key_s[2]),
    .busy(busy_s[2]), .done(done_s[2]), .key_valid(kv_s[2]),
    .rd_idx(rd_idx_s[2]), .rd_key(rd_key_s[2]));

  // Standard AES S-box, row-major
  logic [2047:0] sbox_flat = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  function automatic logic [7:0] sb(input logic [7:0] b);
    return sbox_flat[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sb(x[31:24]), sb(x[23:16]), sb(x[15:8]), sb(x[7:0])};
  endfunction

  function automatic logic [7:0] rcon_of(input int n);
    case (n)
      1: return 8'h01;  2: return 8'h02;  3: return 8'h04;  4: return 8'h08;
      5: return 8'h10;  6: return 8'h20;  7: return 8'h40;  8: return 8'h80;
      9: return 8'h1b; 10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Full schedule for a left-aligned key; word m lives at bits [32*m +: 32]
  function automatic logic [1919:0] expand_key(input logic [255:0] key, input int nk);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [1919:0] ws;
    int            total;
    total = 4 * (nk + 7);
    ws = '0;
    for (int i = 0; i < 60; i++) w[i] = 32'h0;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < total; i++) begin
      t = w[i-1];
      if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rcon_of(i / nk), 24'h0};
      else if (nk > 6 && i % nk == 4) t = subw(t);
      w[i] = w[i-nk] ^ t;
    end
    for (int i = 0; i < 60; i++) ws[32*i +: 32] = w[i];
    return ws;
  endfunction

  function automatic logic [127:0] round_key(input logic [1919:0] ws, input int r);
    return {ws[32*(4*r) +: 32], ws[32*(4*r+1) +: 32],
            ws[32*(4*r+2) +: 32], ws[32*(4*r+3) +: 32]};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Protocol model: remaining busy cycles, done pulse, key_valid and captured schedule
  int            cnt_m   [3];
  logic          done_m  [3];
  logic          kv_m    [3];
  logic [1919:0] words_m [3];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 3; k++) begin
        cnt_m[k]  <= 0;
        done_m[k] <= 1'b0;
        kv_m[k]   <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (done_m[k]) begin
          done_m[k] <= 1'b0;
        end else if (cnt_m[k] > 0) begin
          cnt_m[k] <= cnt_m[k] - 1;
          if (cnt_m[k] == 1) begin
            done_m[k] <= 1'b1;
            kv_m[k]   <= 1'b1;
          end
        end else if (start_s[k]) begin
          cnt_m[k]   <= 40 + 6*k;
          kv_m[k]    <= 1'b0;
          words_m[k] <= expand_key(key_s[k], 4 + 2*k);
        end
      end
    end
  end

  // Compare every instance against the model on each falling edge
  always @(negedge clk) begin
    logic [127:0] erk;
    for (int k = 0; k < 3; k++) begin
      erk = 128'h0;
      if (kv_m[k] && int'(rd_idx_s[k]) <= 10 + 2*k) erk = round_key(words_m[k], int'(rd_idx_s[k]));
      chk($sformatf("busy[%0d]", k), {127'h0, busy_s[k]}, {127'h0, cnt_m[k] > 0});
      chk($sformatf("done[%0d]", k), {127'h0, done_s[k]}, {127'h0, done_m[k]});
      chk($sformatf("key_valid[%0d]", k), {127'h0, kv_s[k]}, {127'h0, kv_m[k]});
      chk($sformatf("rd_key[%0d]", k), rd_key_s[k], erk);
    end
  end

  task automatic run_expand(input int k, input int exp_lat, input string nm);
    int n;
    start_s[k] = 1'b1;
    @(posedge clk); #1;
    start_s[k] = 1'b0;
    key_s[k]   = ~key_s[k];
    n = 0;
    while (done_s[k] !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk(nm, 128'(n), 128'(exp_lat));
  endtask

  task automatic rd_chk(input int k, input logic [3:0] idx, input logic [127:0] exp, input string nm);
    @(posedge clk); #1;
    rd_idx_s[k] = idx;
    #1;
    chk(nm, rd_key_s[k], exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int n_done;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start_s[k]  = 1'b0;
      key_s[k]    = 256'h0;
      rd_idx_s[k] = 4'd0;
    end
    #2 reset = 1'b0;
    start_s[0] = 1'b1;
    start_s[1] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {127'h0, busy_s[0]}, 128'h0);
    chk("rst_done", {127'h0, done_s[0]}, 128'h0);
    chk("rst_kv", {127'h0, kv_s[0]}, 128'h0);
    chk("rst_rdkey", rd_key_s[0], 128'h0);
    start_s[0] = 1'b0;
    start_s[1] = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;

    // Model pinned to published schedules
    chk("model128_r1", round_key(expand_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4), 1),
        128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    chk("model_fips_r10", round_key(expand_key({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4), 10),
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("model256_r14", round_key(expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8), 14),
        128'h24fc79ccbf0979e9371ac23c6d68de36);

    // AES-128 basic vector
    key_s[0] = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    run_expand(0, 40, "lat128");
    rd_chk(0, 4'd0,  128'h000102030405060708090a0b0c0d0e0f, "k128_r0");
    rd_chk(0, 4'd1,  128'hd6aa74fdd2af72fadaa678f1d6ab76fe, "k128_r1");
    rd_chk(0, 4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5, "k128_r10");
    rd_chk(0, 4'd11, 128'h0, "k128_r11");

    // FIPS-197 A.1
    key_s[0] = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    run_expand(0, 40, "lat_fips");
    rd_chk(0, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "fips_r10");

    // AES-192
    key_s[1] = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    run_expand(1, 46, "lat192");
    rd_chk(1, 4'd0,  128'h000102030405060708090a0b0c0d0e0f, "k192_r0");
    rd_chk(1, 4'd12, 128'ha4970a331a78dc09c418c271e3a41d5d, "k192_r12");
    rd_chk(1, 4'd13, 128'h0, "k192_r13");

    // AES-256 (j==4 SubWord path)
    key_s[2] = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    run_expand(2, 52, "lat256");
    rd_chk(2, 4'd1,  128'h101112131415161718191a1b1c1d1e1f, "k256_r1");
    rd_chk(2, 4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36, "k256_r14");
    rd_chk(2, 4'd15, 128'h0, "k256_r15");

    // start held high: one done, then restart in the first IDLE cycle
    key_s[0] = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    start_s[0] = 1'b1;
    @(posedge clk); #1;
    n_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done_s[0] === 1'b1) n_done++;
    end
    chk("held_done_count", 128'(n_done), 128'd1);
    chk("held_done_at_40", {127'h0, done_s[0]}, 128'd1);
    @(posedge clk); #1;
    chk("idle_kv", {127'h0, kv_s[0]}, 128'd1);
    chk("idle_busy", {127'h0, busy_s[0]}, 128'd0);
    @(posedge clk); #1;
    chk("restart_kv", {127'h0, kv_s[0]}, 128'd0);
    chk("restart_busy", {127'h0, busy_s[0]}, 128'd1);
    start_s[0] = 1'b0;
    n = 0;
    while (done_s[0] !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("lat_b2b", 128'(n), 128'd40);
    rd_chk(0, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "b2b_r10");

    // Reset 20 cycles into an expansion
    key_s[0] = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    repeat (20) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("abort_busy", {127'h0, busy_s[0]}, 128'h0);
    chk("abort_done", {127'h0, done_s[0]}, 128'h0);
    chk("abort_kv", {127'h0, kv_s[0]}, 128'h0);
    chk("abort_rdkey", rd_key_s[0], 128'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", {127'h0, done_s[0]}, 128'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    key_s[0] = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    run_expand(0, 40, "lat_after_rst");
    rd_chk(0, 4'd1,  128'hd6aa74fdd2af72fadaa678f1d6ab76fe, "rst_r1");
    rd_chk(0, 4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5, "rst_r10");

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
